// File: rtl/c5_bus_ctrl_if.sv
// Bus bundle between c5_bus_ctrl and its neighbours: CPU look-ahead bus,
// synchronous RAM port, handshaked IO port and the error status line.
interface c5_bus_ctrl_if;
  // CPU side
  logic [31:2] I_cpu_address_next;
  logic [3:0]  I_cpu_byte_we_next;
  logic [31:0] I_cpu_data_w;
  logic [31:0] O_cpu_data_r;
  logic        O_cpu_mem_pause;
  // RAM side
  logic        O_ram_enable;
  logic [3:0]  O_ram_we;
  logic [31:2] O_ram_address;
  logic [31:0] O_ram_data_w;
  logic [31:0] I_ram_data_r;
  // IO side
  logic        O_io_req;
  logic [3:0]  O_io_we;
  logic [31:2] O_io_address;
  logic [31:0] O_io_data_w;
  logic        I_io_ack;
  logic [31:0] I_io_data_r;
  // status
  logic        O_bus_error;

  // slave: the controller; master: CPU + memories around it
  modport slave (
    input  I_cpu_address_next, I_cpu_byte_we_next, I_cpu_data_w,
    input  I_ram_data_r, I_io_ack, I_io_data_r,
    output O_cpu_data_r, O_cpu_mem_pause,
    output O_ram_enable, O_ram_we, O_ram_address, O_ram_data_w,
    output O_io_req, O_io_we, O_io_address, O_io_data_w,
    output O_bus_error
  );

  modport master (
    output I_cpu_address_next, I_cpu_byte_we_next, I_cpu_data_w,
    output I_ram_data_r, I_io_ack, I_io_data_r,
    input  O_cpu_data_r, O_cpu_mem_pause,
    input  O_ram_enable, O_ram_we, O_ram_address, O_ram_data_w,
    input  O_io_req, O_io_we, O_io_address, O_io_data_w,
    input  O_bus_error
  );
endinterface

// File: rtl/c5_bus_ctrl.sv
// Memory-bus controller behind c5_cpu: decodes each look-ahead access to
// single-cycle RAM, a stalling handshaked IO port, or an unmapped bus error.
module c5_bus_ctrl #(
  parameter int unsigned RAM_BYTES  = 4096,
  parameter logic [31:0] IO_BASE    = 32'h2000_0000,
  parameter int unsigned IO_TIMEOUT = 255
) (
  input  logic          I_clk,
  input  logic          I_rst,
  c5_bus_ctrl_if.slave  bus
);

  localparam logic [31:0] RAM_LIM = RAM_BYTES;
  localparam logic [7:0]  TO_LAST = 8'(IO_TIMEOUT - 1);

  typedef enum logic       {IDLE, IO_WAIT} state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_RAM, SRC_IO} src_t;

  typedef struct packed {
    logic [3:0]  we;
    logic [31:2] addr;
    logic [31:0] data;
  } io_req_t;

  state_t      state, state_nx;
  src_t        src, src_nx;
  io_req_t     io_q, io_nx;
  logic [31:0] rd_q, rd_nx;
  logic [7:0]  cnt, cnt_nx;
  logic        err_q, err_nx;
  logic        ram_sel, ram_on;
  logic        hit_ram, hit_io, timeout;

  // RAM wins when the two windows overlap
  assign hit_ram = {bus.I_cpu_address_next, 2'b00} < RAM_LIM;
  assign hit_io  = !hit_ram && (bus.I_cpu_address_next[31:28] == IO_BASE[31:28]);
  assign timeout = (cnt == TO_LAST);

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state <= IDLE;
      src   <= SRC_NONE;
      io_q  <= '0;
      rd_q  <= 32'h0;
      cnt   <= 8'h0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      src   <= src_nx;
      io_q  <= io_nx;
      rd_q  <= rd_nx;
      cnt   <= cnt_nx;
      err_q <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    src_nx   = src;
    io_nx    = io_q;
    rd_nx    = rd_q;
    cnt_nx   = cnt;
    err_nx   = 1'b0;
    ram_sel  = 1'b0;
    unique case (state)
      IDLE: begin
        if (hit_ram) begin
          ram_sel = 1'b1;
          src_nx  = SRC_RAM;
        end else if (hit_io) begin
          io_nx.we   = bus.I_cpu_byte_we_next;
          io_nx.addr = bus.I_cpu_address_next;
          io_nx.data = bus.I_cpu_data_w;
          cnt_nx     = 8'h0;
          state_nx   = IO_WAIT;
        end else begin
          // unmapped: write dropped, read returns zero, error next cycle
          err_nx = 1'b1;
          src_nx = SRC_NONE;
        end
      end
      IO_WAIT: begin
        // ack beats a timeout landing on the same cycle
        if (bus.I_io_ack) begin
          rd_nx    = bus.I_io_data_r;
          src_nx   = SRC_IO;
          cnt_nx   = 8'h0;
          state_nx = IDLE;
        end else if (timeout) begin
          rd_nx    = 32'h0;
          src_nx   = SRC_IO;
          err_nx   = 1'b1;
          cnt_nx   = 8'h0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // RAM port is a straight pass-through, held at zero during reset
  assign ram_on            = ram_sel & ~I_rst;
  assign bus.O_ram_enable  = ram_on;
  assign bus.O_ram_we      = ram_on ? bus.I_cpu_byte_we_next : 4'h0;
  assign bus.O_ram_address = I_rst ? 30'h0 : bus.I_cpu_address_next;
  assign bus.O_ram_data_w  = I_rst ? 32'h0 : bus.I_cpu_data_w;

  assign bus.O_io_req        = (state == IO_WAIT);
  assign bus.O_cpu_mem_pause = (state == IO_WAIT);
  assign bus.O_io_we         = io_q.we;
  assign bus.O_io_address    = io_q.addr;
  assign bus.O_io_data_w     = io_q.data;
  assign bus.O_bus_error     = err_q;

  always_comb begin
    bus.O_cpu_data_r = 32'h0;
    case (src)
      SRC_RAM: bus.O_cpu_data_r = bus.I_ram_data_r;
      SRC_IO:  bus.O_cpu_data_r = rd_q;
      default: bus.O_cpu_data_r = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_c5_bus_ctrl.sv
// Directed bench for c5_bus_ctrl with a tiny synchronous RAM model; IO side
// is driven by hand, IO_TIMEOUT shortened to 4.
module tb_c5_bus_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  c5_bus_ctrl_if b ();

  c5_bus_ctrl #(
    .RAM_BYTES  (4096),
    .IO_BASE    (32'h2000_0000),
    .IO_TIMEOUT (4)
  ) dut (
    .I_clk (clk),
    .I_rst (rst),
    .bus   (b.slave)
  );

  // 16-word RAM model, data one cycle after enable, cleared by reset
  logic [31:0] mem [16];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      b.I_ram_data_r <= 32'h0;
    end else if (b.O_ram_enable) begin
      b.I_ram_data_r <= mem[b.O_ram_address[5:2]];
      for (int j = 0; j < 4; j++)
        if (b.O_ram_we[j]) mem[b.O_ram_address[5:2]][j*8 +: 8] <= b.O_ram_data_w[j*8 +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
    b.I_cpu_address_next = a[31:2];
    b.I_cpu_byte_we_next = we;
    b.I_cpu_data_w       = d;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    b.I_io_ack    = 1'b0;
    b.I_io_data_r = 32'h0;
    drive(32'h10, 4'hF, 32'h5555_5555);
    #2;
    // reset state, RAM port forced low
    chk("rst_pause",  b.O_cpu_mem_pause, 0);
    chk("rst_req",    b.O_io_req, 0);
    chk("rst_io_we",  b.O_io_we, 0);
    chk("rst_io_adr", b.O_io_address, 0);
    chk("rst_io_dw",  b.O_io_data_w, 0);
    chk("rst_err",    b.O_bus_error, 0);
    chk("rst_dr",     b.O_cpu_data_r, 0);
    chk("rst_ram_en", b.O_ram_enable, 0);
    chk("rst_ram_we", b.O_ram_we, 0);
    chk("rst_ram_ad", b.O_ram_address, 0);
    chk("rst_ram_dw", b.O_ram_data_w, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // RAM write then read of 0x10
    drive(32'h10, 4'hF, 32'hCAFE_BABE);
    smp();
    chk("ramw_en",  b.O_ram_enable, 1);
    chk("ramw_we",  b.O_ram_we, 4'hF);
    chk("ramw_adr", b.O_ram_address, 30'h4);
    chk("ramw_dw",  b.O_ram_data_w, 32'hCAFE_BABE);
    chk("ramw_pz",  b.O_cpu_mem_pause, 0);
    cyc();
    drive(32'h10, 4'h0, 32'h0);
    smp();
    chk("ramr_en",  b.O_ram_enable, 1);
    chk("ramr_we",  b.O_ram_we, 0);
    chk("ramr_pz",  b.O_cpu_mem_pause, 0);
    cyc();
    drive(32'h0, 4'h0, 32'h0);
    smp();
    chk("ramr_dr",  b.O_cpu_data_r, 32'hCAFE_BABE);
    chk("ramr_pz2", b.O_cpu_mem_pause, 0);

    // IO read, ack in the third IO_WAIT cycle
    cyc();
    drive(32'h2000_0004, 4'h0, 32'h0);
    smp();
    chk("ior_req0", b.O_io_req, 0);
    chk("ior_pz0",  b.O_cpu_mem_pause, 0);
    chk("ior_ram0", b.O_ram_enable, 0);
    cyc();
    smp();
    chk("ior_req1", b.O_io_req, 1);
    chk("ior_pz1",  b.O_cpu_mem_pause, 1);
    chk("ior_adr",  b.O_io_address, 30'h0800_0001);
    chk("ior_we",   b.O_io_we, 0);
    chk("ior_ram1", b.O_ram_enable, 0);
    cyc();
    smp();
    chk("ior_pz2",  b.O_cpu_mem_pause, 1);
    cyc();
    b.I_io_ack    = 1'b1;
    b.I_io_data_r = 32'h1234_5678;
    smp();
    chk("ior_pz3",  b.O_cpu_mem_pause, 1);
    cyc();
    b.I_io_ack    = 1'b0;
    b.I_io_data_r = 32'hDEAD_BEEF;
    drive(32'h10, 4'h0, 32'h0);
    smp();
    chk("ior_pz4",  b.O_cpu_mem_pause, 0);
    chk("ior_req4", b.O_io_req, 0);
    chk("ior_dr",   b.O_cpu_data_r, 32'h1234_5678);
    chk("ior_err",  b.O_bus_error, 0);
    chk("ior_next", b.O_ram_enable, 1);
    cyc();
    drive(32'h0, 4'h0, 32'h0);
    smp();
    chk("ior_ramdr", b.O_cpu_data_r, 32'hCAFE_BABE);

    // IO write, immediate ack
    cyc();
    drive(32'h2000_0008, 4'h3, 32'h0000_BEEF);
    smp();
    cyc();
    b.I_io_ack    = 1'b1;
    b.I_io_data_r = 32'h0;
    smp();
    chk("iow_req", b.O_io_req, 1);
    chk("iow_we",  b.O_io_we, 4'h3);
    chk("iow_dw",  b.O_io_data_w, 32'h0000_BEEF);
    chk("iow_adr", b.O_io_address, 30'h0800_0002);
    cyc();
    b.I_io_ack = 1'b0;
    drive(32'h0, 4'h0, 32'h0);
    smp();
    chk("iow_pz",  b.O_cpu_mem_pause, 0);
    chk("iow_req2", b.O_io_req, 0);
    chk("iow_err", b.O_bus_error, 0);

    // IO timeout: req high for 4 cycles, then error pulse and zero data
    cyc();
    b.I_io_data_r = 32'hFFFF_FFFF;
    drive(32'h2000_000C, 4'h0, 32'h0);
    smp();
    for (int i = 0; i < 4; i++) begin
      cyc();
      smp();
      chk("to_req", b.O_io_req, 1);
      chk("to_err_lo", b.O_bus_error, 0);
    end
    cyc();
    drive(32'h10, 4'h0, 32'h0);
    smp();
    chk("to_req_dn", b.O_io_req, 0);
    chk("to_pz_dn",  b.O_cpu_mem_pause, 0);
    chk("to_err",    b.O_bus_error, 1);
    chk("to_dr",     b.O_cpu_data_r, 0);
    chk("to_ram_en", b.O_ram_enable, 1);
    cyc();
    drive(32'h0FFC, 4'h0, 32'h0);
    smp();
    chk("to_err_end", b.O_bus_error, 0);
    chk("to_ram_dr",  b.O_cpu_data_r, 32'hCAFE_BABE);
    chk("bnd_ram",    b.O_ram_enable, 1);

    // unmapped read at RAM_BYTES, then unmapped write
    cyc();
    drive(32'h0000_1000, 4'h0, 32'h0);
    smp();
    chk("um_ram0", b.O_ram_enable, 0);
    chk("um_req0", b.O_io_req, 0);
    cyc();
    drive(32'h4000_0000, 4'hF, 32'h1111_1111);
    smp();
    chk("um_err1", b.O_bus_error, 1);
    chk("um_dr1",  b.O_cpu_data_r, 0);
    chk("um_ram1", b.O_ram_enable, 0);
    chk("um_rwe1", b.O_ram_we, 0);
    chk("um_req1", b.O_io_req, 0);
    cyc();
    drive(32'h0, 4'h0, 32'h0);
    smp();
    chk("um_err2", b.O_bus_error, 1);
    chk("um_dr2",  b.O_cpu_data_r, 0);
    chk("um_req2", b.O_io_req, 0);
    cyc();
    smp();
    chk("um_err3", b.O_bus_error, 0);

    // reset two cycles into IO_WAIT, stale ack afterwards
    cyc();
    drive(32'h2000_0010, 4'h0, 32'h0);
    smp();
    cyc();
    smp();
    cyc();
    chk("mr_req_pre", b.O_io_req, 1);
    #2 rst = 1'b1;
    drive(32'h0, 4'h0, 32'h0);
    #1;
    chk("mr_req_dn", b.O_io_req, 0);
    chk("mr_pz_dn",  b.O_cpu_mem_pause, 0);
    chk("mr_ram_en", b.O_ram_enable, 0);
    cyc();
    rst = 1'b0;
    b.I_io_ack    = 1'b1;
    b.I_io_data_r = 32'hA5A5_A5A5;
    smp();
    chk("mr_req_ack", b.O_io_req, 0);
    chk("mr_pz_ack",  b.O_cpu_mem_pause, 0);
    chk("mr_dr_ack",  b.O_cpu_data_r, 0);
    chk("mr_io_adr",  b.O_io_address, 0);
    cyc();
    b.I_io_ack = 1'b0;
    smp();
    chk("mr_req_fin", b.O_io_req, 0);
    chk("mr_pz_fin",  b.O_cpu_mem_pause, 0);
    chk("mr_err_fin", b.O_bus_error, 0);
    chk("mr_dr_fin",  b.O_cpu_data_r, 0);
    chk("mr_iowe",    b.O_io_we, 0);
    chk("mr_iodw",    b.O_io_data_w, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
